// File: rtl/pipe_ctrl_pkg.sv
// Shared types, state encodings and the load-use hazard test for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

    typedef enum logic [1:0] {
        PCTL_RUN     = 2'd0,
        PCTL_MC_WAIT = 2'd1,
        PCTL_MC_DONE = 2'd2,
        PCTL_REFILL  = 2'd3
    } pctl_state_e;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use(
        input logic          mem_rd,
        input reg_addr_bus_t rd,
        input logic          use_r1,
        input reg_addr_bus_t r1,
        input logic          use_r2,
        input reg_addr_bus_t r2
    );
        return mem_rd && (rd != '0) &&
               ((use_r1 && (r1 == rd)) || (use_r2 && (r2 == rd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Loadable down-counter with a zero flag; times the occupancy of a multi-cycle EX op.
module pipe_ctrl_mc_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, multi-cycle EX freeze
// and wrap-around debug counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 33,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_addr_bus_t    id_r1_i,
    input  reg_addr_bus_t    id_r2_i,
    input  logic             id_use_r1_i,
    input  logic             id_use_r2_i,
    input  reg_addr_bus_t    idex_rd_i,
    input  logic             idex_mem_rd_i,
    input  logic             ex_mc_i,
    input  logic             br_jmp_en_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             idex_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_bubble_o,
    output logic             mc_start_o,
    output logic             mc_done_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int TMR_W = $clog2(MC_CYCLES);

    pctl_state_e      state_q;
    pctl_state_e      state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic lu;
    logic pc_stall_c, ifid_stall_c, idex_stall_c;
    logic ifid_flush_c, idex_flush_c, exmem_bubble_c;
    logic mc_start_c, mc_done_c, flush_inc_c;
    logic tmr_load_c, tmr_dec_c, tmr_zero;

    assign lu = load_use(idex_mem_rd_i, idex_rd_i, id_use_r1_i, id_r1_i, id_use_r2_i, id_r2_i);

    always_comb begin
        state_d        = state_q;
        pc_stall_c     = 1'b0;
        ifid_stall_c   = 1'b0;
        idex_stall_c   = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_flush_c   = 1'b0;
        exmem_bubble_c = 1'b0;
        mc_start_c     = 1'b0;
        mc_done_c      = 1'b0;
        flush_inc_c    = 1'b0;
        tmr_load_c     = 1'b0;
        tmr_dec_c      = 1'b0;

        unique case (state_q)
            PCTL_RUN: begin
                if (br_jmp_en_i) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    flush_inc_c  = 1'b1;
                    state_d      = PCTL_REFILL;
                end else if (ex_mc_i) begin
                    mc_start_c     = 1'b1;
                    pc_stall_c     = 1'b1;
                    ifid_stall_c   = 1'b1;
                    idex_stall_c   = 1'b1;
                    exmem_bubble_c = 1'b1;
                    tmr_load_c     = 1'b1;
                    state_d        = PCTL_MC_WAIT;
                end else if (lu) begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_flush_c = 1'b1;
                end
            end
            PCTL_MC_WAIT: begin
                pc_stall_c     = 1'b1;
                ifid_stall_c   = 1'b1;
                idex_stall_c   = 1'b1;
                exmem_bubble_c = 1'b1;
                if (tmr_zero) begin
                    state_d = PCTL_MC_DONE;
                end else begin
                    tmr_dec_c = 1'b1;
                end
            end
            PCTL_MC_DONE: begin
                // Result leaves EX this cycle; ex_mc_i still reads high but must not restart.
                mc_done_c = 1'b1;
                if (lu) begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_flush_c = 1'b1;
                end
                state_d = PCTL_RUN;
            end
            PCTL_REFILL: begin
                // The synchronous imem returns the wrong-path fetch one cycle late.
                ifid_flush_c = 1'b1;
                state_d      = PCTL_RUN;
            end
            default: state_d = PCTL_RUN;
        endcase

        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall_c);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PCTL_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    pipe_ctrl_mc_timer #(
        .W (TMR_W)
    ) mc_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_c),
        .load_val_i (TMR_W'(MC_CYCLES - 2)),
        .dec_i      (tmr_dec_c),
        .zero_o     (tmr_zero)
    );

    // Reset forces every control output low even before the state flops settle.
    assign pc_stall_o     = rst & pc_stall_c;
    assign ifid_stall_o   = rst & ifid_stall_c;
    assign idex_stall_o   = rst & idex_stall_c;
    assign ifid_flush_o   = rst & ifid_flush_c;
    assign idex_flush_o   = rst & idex_flush_c;
    assign exmem_bubble_o = rst & exmem_bubble_c;
    assign mc_start_o     = rst & mc_start_c;
    assign mc_done_o      = rst & mc_done_c;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (4-cycle op / 4-bit counters, and 2-cycle op / 32-bit
// counters) driven in lockstep and compared against a cycle-level behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    reg_addr_bus_t id_r1 = '0, id_r2 = '0, idex_rd = '0;
    logic          u1 = 0, u2 = 0, mem_rd = 0, ex_mc = 0, br = 0;

    logic        a_pcs, a_ifs, a_ids, a_iff, a_idf, a_bub, a_st, a_dn;
    logic [3:0]  a_scnt, a_fcnt;
    logic        b_pcs, b_ifs, b_ids, b_iff, b_idf, b_bub, b_st, b_dn;
    logic [31:0] b_scnt, b_fcnt;

    pipe_ctrl #(.MC_CYCLES(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_r1_i(id_r1), .id_r2_i(id_r2),
        .id_use_r1_i(u1), .id_use_r2_i(u2), .idex_rd_i(idex_rd), .idex_mem_rd_i(mem_rd),
        .ex_mc_i(ex_mc), .br_jmp_en_i(br),
        .pc_stall_o(a_pcs), .ifid_stall_o(a_ifs), .idex_stall_o(a_ids), .ifid_flush_o(a_iff),
        .idex_flush_o(a_idf), .exmem_bubble_o(a_bub), .mc_start_o(a_st), .mc_done_o(a_dn),
        .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt));

    pipe_ctrl #(.MC_CYCLES(2), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .id_r1_i(id_r1), .id_r2_i(id_r2),
        .id_use_r1_i(u1), .id_use_r2_i(u2), .idex_rd_i(idex_rd), .idex_mem_rd_i(mem_rd),
        .ex_mc_i(ex_mc), .br_jmp_en_i(br),
        .pc_stall_o(b_pcs), .ifid_stall_o(b_ifs), .idex_stall_o(b_ids), .ifid_flush_o(b_iff),
        .idex_flush_o(b_idf), .exmem_bubble_o(b_bub), .mc_start_o(b_st), .mc_done_o(b_dn),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt));

    int total = 0;
    int bad   = 0;

    // Flag vector order: pc_stall ifid_stall idex_stall ifid_flush idex_flush bubble start done
    localparam logic [7:0] F_FREEZE = 8'b1110_0100;
    localparam logic [7:0] F_START  = 8'b0000_0010;
    localparam logic [7:0] F_DONE   = 8'b0000_0001;
    localparam logic [7:0] F_LU     = 8'b1100_1000;
    localparam logic [7:0] F_BR     = 8'b0001_1000;
    localparam logic [7:0] F_REFILL = 8'b0001_0000;

    // Model: pending refill, freeze cycles still owed, pending done, raw event counts.
    logic            m_refill [2];
    int              m_left   [2];
    logic            m_done   [2];
    longint unsigned m_stall  [2];
    longint unsigned m_flush  [2];
    int              mc_len   [2] = '{4, 2};
    int              cnt_w    [2] = '{4, 32};

    function automatic logic [7:0] obs_flags(input int k);
        if (k == 0) return {a_pcs, a_ifs, a_ids, a_iff, a_idf, a_bub, a_st, a_dn};
        return {b_pcs, b_ifs, b_ids, b_iff, b_idf, b_bub, b_st, b_dn};
    endfunction

    function automatic logic [63:0] obs_cnts(input int k);
        if (k == 0) return {28'd0, a_scnt, 28'd0, a_fcnt};
        return {b_scnt, b_fcnt};
    endfunction

    function automatic logic [63:0] exp_cnts(input int k);
        longint unsigned m;
        m = (64'd1 << cnt_w[k]) - 64'd1;
        if (!rst) return 64'd0;
        return {32'(m_stall[k] & m), 32'(m_flush[k] & m)};
    endfunction

    task automatic model_eval(input int k, output logic [7:0] e);
        logic lu;
        lu = mem_rd && (idex_rd != 0) &&
             ((u1 && id_r1 == idex_rd) || (u2 && id_r2 == idex_rd));
        e = 8'd0;
        if (!rst) begin
            m_refill[k] = 0; m_left[k] = 0; m_done[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            return;
        end
        if (m_refill[k]) begin
            e = F_REFILL; m_refill[k] = 0;
        end else if (m_left[k] > 0) begin
            e = F_FREEZE; m_left[k]--;
            if (m_left[k] == 0) m_done[k] = 1;
        end else if (m_done[k]) begin
            e = F_DONE | (lu ? F_LU : 8'd0); m_done[k] = 0;
        end else if (br) begin
            e = F_BR; m_flush[k]++; m_refill[k] = 1;
        end else if (ex_mc) begin
            e = F_FREEZE | F_START; m_left[k] = mc_len[k] - 1;
        end else if (lu) begin
            e = F_LU;
        end
        if (e[7]) m_stall[k]++;
    endtask

    task automatic set_in(input int r1, input int r2, input logic iu1, input logic iu2,
                          input int rd, input logic mr, input logic mc, input logic b);
        id_r1 = reg_addr_bus_t'(r1); id_r2 = reg_addr_bus_t'(r2);
        u1 = iu1; u2 = iu2; idex_rd = reg_addr_bus_t'(rd);
        mem_rd = mr; ex_mc = mc; br = b;
    endtask

    task automatic test_reset();
        logic [7:0] e; logic [63:0] ec;
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(5, 5, 1, 1, 5, 1, i[0], ~i[0]);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ec = exp_cnts(k); model_eval(k, e);
                total += 2;
                if (obs_flags(k) !== e) begin bad++; $display("FAIL reset[%0d] flags=%b want %b", k, obs_flags(k), e); end
                if (obs_cnts(k) !== ec) begin bad++; $display("FAIL reset[%0d] cnts=%h want %h", k, obs_cnts(k), ec); end
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        logic [7:0] e; logic [63:0] ec;
        // hazard, load moved on, rd=x0, rs2 unused, idle
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_in(0, 5, 0, 1, 5, 1, 0, 0);
                1: set_in(0, 5, 0, 1, 5, 0, 0, 0);
                2: set_in(0, 0, 0, 1, 0, 1, 0, 0);
                3: set_in(0, 5, 0, 0, 5, 1, 0, 0);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ec = exp_cnts(k); model_eval(k, e);
                total += 2;
                if (obs_flags(k) !== e) begin bad++; $display("FAIL load_use[%0d.%0d] flags=%b want %b", i, k, obs_flags(k), e); end
                if (obs_cnts(k) !== ec) begin bad++; $display("FAIL load_use[%0d.%0d] cnts=%h want %h", i, k, obs_cnts(k), ec); end
            end
            @(posedge clk); #1;
        end
        total++;
        if (a_scnt !== 4'd1) begin bad++; $display("FAIL load_use_stall_cnt got %0d want 1", a_scnt); end
    endtask

    task automatic test_branch_hazard();
        logic [7:0] e; logic [63:0] ec;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_in(7, 0, 1, 0, 7, 1, 0, 1);
                1: set_in(7, 0, 1, 0, 7, 1, 1, 1);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ec = exp_cnts(k); model_eval(k, e);
                total += 2;
                if (obs_flags(k) !== e) begin bad++; $display("FAIL branch[%0d.%0d] flags=%b want %b", i, k, obs_flags(k), e); end
                if (obs_cnts(k) !== ec) begin bad++; $display("FAIL branch[%0d.%0d] cnts=%h want %h", i, k, obs_cnts(k), ec); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multicycle();
        logic [7:0] e; logic [63:0] ec;
        // ex_mc held 6 cycles, then a short op with a load-use pair landing in MC_DONE
        for (int i = 0; i < 18; i++) begin
            if (i < 6)        set_in(0, 0, 0, 0, 0, 0, 1, 0);
            else if (i == 12) set_in(0, 0, 0, 0, 0, 0, 1, 0);
            else if (i == 13 || i == 14) set_in(3, 0, 1, 0, 3, 1, 0, 0);
            else              set_in(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ec = exp_cnts(k); model_eval(k, e);
                total += 2;
                if (obs_flags(k) !== e) begin bad++; $display("FAIL multicycle[%0d.%0d] flags=%b want %b", i, k, obs_flags(k), e); end
                if (obs_cnts(k) !== ec) begin bad++; $display("FAIL multicycle[%0d.%0d] cnts=%h want %h", i, k, obs_cnts(k), ec); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] e; logic [63:0] ec;
        for (int i = 0; i < 10; i++) begin
            rst = !(i == 2 || i == 3);
            set_in(0, 0, 0, 0, 0, 0, (i == 0 || i == 4), 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ec = exp_cnts(k); model_eval(k, e);
                total += 2;
                if (obs_flags(k) !== e) begin bad++; $display("FAIL reset_mid_op[%0d.%0d] flags=%b want %b", i, k, obs_flags(k), e); end
                if (obs_cnts(k) !== ec) begin bad++; $display("FAIL reset_mid_op[%0d.%0d] cnts=%h want %h", i, k, obs_cnts(k), ec); end
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] e; logic [63:0] ec;
        for (int i = 0; i < 36; i++) begin
            rst = (i != 0);
            set_in(0, 0, 0, 0, 0, 0, 0, (i >= 1 && i <= 34));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ec = exp_cnts(k); model_eval(k, e);
                total += 2;
                if (obs_flags(k) !== e) begin bad++; $display("FAIL wrap[%0d.%0d] flags=%b want %b", i, k, obs_flags(k), e); end
                if (obs_cnts(k) !== ec) begin bad++; $display("FAIL wrap[%0d.%0d] cnts=%h want %h", i, k, obs_cnts(k), ec); end
            end
            @(posedge clk); #1;
        end
        total += 2;
        if (a_fcnt !== 4'd1)   begin bad++; $display("FAIL wrap_flush_cnt4 got %0d want 1", a_fcnt); end
        if (b_fcnt !== 32'd17) begin bad++; $display("FAIL wrap_flush_cnt32 got %0d want 17", b_fcnt); end
    endtask

    task automatic test_random();
        logic [7:0] e; logic [63:0] ec;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ec = exp_cnts(k); model_eval(k, e);
                total += 2;
                if (obs_flags(k) !== e) begin bad++; $display("FAIL random[%0d.%0d] flags=%b want %b", i, k, obs_flags(k), e); end
                if (obs_cnts(k) !== ec) begin bad++; $display("FAIL random[%0d.%0d] cnts=%h want %h", i, k, obs_cnts(k), ec); end
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_multicycle();
        test_reset_mid_op();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
